// File: rtl/i2c_tx_feeder.sv
// Byte FIFO that feeds an I2C byte sender one complete transaction at a time,
// pacing offers on the sender's byte_done handshake and flushing on a stall.
module i2c_tx_feeder #(
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [7:0]                wr_data,
    input  logic                      wr_last,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      pre_ready,
    output logic [7:0]                pre_data,
    input  logic                      byte_done,
    output logic                      busy,
    output logic                      txn_done,
    output logic                      timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_L   = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OFFER   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        GAP     = 3'd4,
        FLUSH   = 3'd5
    } state_t;

    logic [8:0]    mem [DEPTH];
    logic [8:0]    head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [AW:0]   txn_cnt_q, txn_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    state_t        state_q, state_d;
    logic          gap_q, gap_d;
    logic          last_q, last_d;
    logic [7:0]    pre_data_q, pre_data_d;
    logic          txn_done_q, txn_done_d;
    logic          tmo_err_q, tmo_err_d;
    logic          push, pop, tmo_hit;

    assign head    = mem[rd_ptr_q];
    assign full    = (level_q == DEPTH_L);
    assign push    = wr_en && !full;
    assign tmo_hit = (tmo_q == TMO_L);

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        txn_cnt_d = txn_cnt_q;
        case ({push && wr_last, pop && head[8]})
            2'b10:   txn_cnt_d = txn_cnt_q + 1'b1;
            2'b01:   txn_cnt_d = txn_cnt_q - 1'b1;
            default: txn_cnt_d = txn_cnt_q;
        endcase
    end

    // Only complete transactions are started, so every pop below finds an entry.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        last_d     = last_q;
        pre_data_d = pre_data_q;
        txn_done_d = 1'b0;
        tmo_err_d  = tmo_err_q;
        case (state_q)
            IDLE: begin
                if (txn_cnt_q != '0) begin
                    state_d    = OFFER;
                    pre_data_d = head[7:0];
                end
            end
            OFFER: begin
                pop     = 1'b1;
                last_d  = head[8];
                tmo_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI, WAIT_LO: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                    gap_d     = 1'b0;
                    state_d   = last_q ? GAP : FLUSH;
                end else if (state_q == WAIT_HI) begin
                    if (byte_done) state_d = WAIT_LO;
                end else if (!byte_done) begin
                    if (last_q) begin
                        txn_done_d = 1'b1;
                        gap_d      = 1'b0;
                        state_d    = GAP;
                    end else begin
                        pre_data_d = head[7:0];
                        state_d    = OFFER;
                    end
                end
            end
            FLUSH: begin
                pop = 1'b1;
                if (head[8]) begin
                    gap_d   = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q) state_d = IDLE;
                else       gap_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {wr_last, wr_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            txn_cnt_q  <= '0;
            tmo_q      <= '0;
            gap_q      <= 1'b0;
            last_q     <= 1'b0;
            pre_data_q <= '0;
            txn_done_q <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q   <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            level_q    <= level_d;
            txn_cnt_q  <= txn_cnt_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            pre_data_q <= pre_data_d;
            txn_done_q <= txn_done_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign level       = level_q;
    assign pre_ready   = (state_q == OFFER);
    assign pre_data    = pre_data_q;
    assign busy        = (state_q != IDLE);
    assign txn_done    = txn_done_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_i2c_tx_feeder.sv
// Scoreboard bench for i2c_tx_feeder: stimulus queues the bytes that must be
// offered, a negedge monitor checks every pre_ready pulse against that queue.
module tb_i2c_tx_feeder;

    localparam int DEPTH = 16;
    localparam int TMO   = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_last = 1'b0;
    logic       byte_done = 1'b0;
    logic       full;
    logic [4:0] level;
    logic       pre_ready;
    logic [7:0] pre_data;
    logic       busy;
    logic       txn_done;
    logic       timeout_err;

    i2c_tx_feeder #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_last(wr_last), .full(full), .level(level), .pre_ready(pre_ready),
        .pre_data(pre_data), .byte_done(byte_done), .busy(busy),
        .txn_done(txn_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int txn_seen = 0;
    int offers_seen = 0;
    int gap_checks = 0;
    int last_td = -1;
    int last_offer = 0;
    bit sender_en = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every offer must match the head of the expected-byte queue.
    always @(negedge clk) begin
        if (rst_n && txn_done) begin
            txn_seen++;
            last_td = cyc;
        end
        if (rst_n && pre_ready) begin
            offers_seen++;
            last_offer = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_offer: got %02h expected no offer", pre_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("offer_data", {24'd0, pre_data}, {24'd0, mon_e});
            end
            if (last_td >= 0) begin
                gap_checks++;
                chk("txn_gap_ge3", {31'd0, (cyc - last_td) >= 3}, 32'd1);
                last_td = -1;
            end
        end
    end

    // Sender model: byte_done rises 20 cycles after an offer and stays high 2 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (pre_ready && sender_en) begin
                repeat (20) @(negedge clk);
                byte_done = 1'b1;
                repeat (2) @(negedge clk);
                byte_done = 1'b0;
            end
        end
    end

    task automatic wr(input logic [7:0] d, input logic l, input bit expect_tx);
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = l;
        if (expect_tx) exp_q.push_back(d);
        @(negedge clk);
        wr_en   = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(busy == 1'b0 && level == 5'd0 && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_in_time"}, {31'd0, n < budget}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pre_ready"}, {31'd0, pre_ready}, 32'd0);
        chk({tag, "_pre_data"}, {24'd0, pre_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_txn_done"}, {31'd0, txn_done}, 32'd0);
        chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
        chk({tag, "_full"}, {31'd0, full}, 32'd0);
        chk({tag, "_level"}, {27'd0, level}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_txn, base_off, base_gap, n;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic three-byte transaction
        base_txn = txn_seen;
        wr(8'hA0, 1'b0, 1'b1);
        wr(8'h10, 1'b0, 1'b1);
        wr(8'h55, 1'b1, 1'b1);
        wait_idle(300, "t1");
        chk("t1_txn_done_cnt", txn_seen - base_txn, 32'd1);
        chk("t1_level", {27'd0, level}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // Partial transaction must not start until its last byte arrives
        base_txn = txn_seen;
        base_off = offers_seen;
        wr(8'hA0, 1'b0, 1'b1);
        wr(8'h10, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("t2_no_offer", offers_seen - base_off, 32'd0);
        chk("t2_level", {27'd0, level}, 32'd2);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        wr(8'h22, 1'b1, 1'b1);
        n = 1;
        while (!pre_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t2_start_within_2", {31'd0, n <= 2}, 32'd1);
        wait_idle(300, "t2");
        chk("t2_txn_done_cnt", txn_seen - base_txn, 32'd1);

        // Fill to DEPTH, then one more write that must be dropped
        base_txn = txn_seen;
        for (int i = 0; i < DEPTH; i++) wr(8'h30 + 8'(i), (i == DEPTH - 1), 1'b1);
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_level", {27'd0, level}, DEPTH);
        wr(8'hEE, 1'b1, 1'b0);
        wait_idle(800, "t3");
        chk("t3_txn_done_cnt", txn_seen - base_txn, 32'd1);
        chk("t3_level_end", {27'd0, level}, 32'd0);

        // Two back-to-back two-byte transactions
        base_txn = txn_seen;
        base_gap = gap_checks;
        wr(8'hB1, 1'b0, 1'b1);
        wr(8'hB2, 1'b1, 1'b1);
        wr(8'hC1, 1'b0, 1'b1);
        wr(8'hC2, 1'b1, 1'b1);
        wait_idle(300, "t4");
        chk("t4_txn_done_cnt", txn_seen - base_txn, 32'd2);
        chk("t4_gap_checked", gap_checks - base_gap, 32'd2);

        // Stalled sender: timeout, flush D2, then E1 goes out normally
        sender_en = 1'b0;
        base_txn = txn_seen;
        wr(8'hD1, 1'b0, 1'b1);
        wr(8'hD2, 1'b1, 1'b0);
        wr(8'hE1, 1'b1, 1'b1);
        n = 0;
        while (!timeout_err && n < TMO + 50) begin
            @(negedge clk);
            n++;
        end
        sender_en = 1'b1;
        chk("t5_timeout_seen", {31'd0, timeout_err}, 32'd1);
        chk("t5_timeout_latency", cyc - last_offer, TMO + 2);
        wait_idle(300, "t5");
        chk("t5_txn_done_cnt", txn_seen - base_txn, 32'd1);
        chk("t5_timeout_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset while waiting for byte_done abandons the transaction
        base_txn = txn_seen;
        wr(8'hF1, 1'b0, 1'b1);
        wr(8'hF2, 1'b1, 1'b0);
        n = 0;
        while (!pre_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t6_offer_seen", {31'd0, pre_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t6_in_wait", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("t6_rst");
        rst_n = 1'b1;
        base_off = offers_seen;
        repeat (40) @(negedge clk);
        chk("t6_no_offer_after_rst", offers_seen - base_off, 32'd0);
        chk("t6_level_after_rst", {27'd0, level}, 32'd0);
        chk("t6_txn_done_cnt", txn_seen - base_txn, 32'd0);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
